// File: rtl/alu_macro_seq.sv
// alu_macro_seq
// Sequencer that builds compound 16-bit operations (SUB, AND, OR, XOR, SHL,
// CMPEQ, and MUL when ALU_MACRO_SEQ_MUL_EN is defined) from the four-function
// core ALU (ADD, NAND, PASS1, EQ). One ALU micro-step is issued per clock.
// The ALU drive outputs are combinational from (op, step, regs). The step
// result is captured on the clock edge.
// Optional feature macro: ALU_MACRO_SEQ_MUL_EN (op 5 = MUL, 32 steps).
module alu_macro_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_err,
  output logic             busy,
  output logic [1:0]       alu_func,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_eq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_SUB   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_SHL   = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_CMPEQ = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_NAND = 2'b01;
  localparam logic [1:0] FN_PASS = 2'b10;
  localparam logic [1:0] FN_EQ   = 2'b11;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, t0_q, t0_d, t1_q, t1_d;
  logic [4:0]       step_q, step_d, last_idx_s;
  logic             last_step_s, op_illegal_s;
  logic [WIDTH-1:0] resp_result_q, res_d;
  logic             resp_err_q, err_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic             req_ready_q, req_ready_d;
`ifdef ALU_MACRO_SEQ_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

`ifdef ALU_MACRO_SEQ_MUL_EN
  assign op_illegal_s = (req_op == OP_RSVD);
`else
  assign op_illegal_s = (req_op == OP_RSVD) || (req_op == OP_MUL);
`endif

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;

  // Index of the final micro-step for the operation in flight
  always_comb begin
    last_idx_s = 5'd0;
    case (op_q)
      OP_SUB:   last_idx_s = 5'd2;
      OP_AND:   last_idx_s = 5'd1;
      OP_OR:    last_idx_s = 5'd2;
      OP_XOR:   last_idx_s = 5'd3;
      OP_SHL: begin
        if (b_q[3:0] == 4'd0) last_idx_s = 5'd0;
        else                  last_idx_s = {1'b0, b_q[3:0]} - 5'd1;
      end
      OP_CMPEQ: last_idx_s = 5'd0;
`ifdef ALU_MACRO_SEQ_MUL_EN
      OP_MUL:   last_idx_s = 5'd31;
`endif
      default:  last_idx_s = 5'd0;
    endcase
  end

  assign last_step_s = (step_q == last_idx_s);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: illegal opcodes skip EXEC and answer immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (op_illegal_s) state_d = ST_DONE;
          else              state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (last_step_s) state_d = ST_DONE;
        else             state_d = ST_EXEC;
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
        else            state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake/status outputs, registered from the next state
  always_comb begin
    resp_valid_d = 1'b0;
    busy_d       = 1'b0;
    req_ready_d  = 1'b0;
    case (state_d)
      ST_IDLE: req_ready_d = 1'b1;
      ST_EXEC: busy_d      = 1'b1;
      ST_DONE: begin
        busy_d       = 1'b1;
        resp_valid_d = 1'b1;
      end
      default: req_ready_d = 1'b1;
    endcase
  end

  // ALU drive: PASS1 of zero outside EXEC, otherwise the current micro-step
  always_comb begin
    alu_func = FN_PASS;
    alu_op1  = ZERO;
    alu_op2  = ZERO;
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_SUB: begin
          if (step_q == 5'd0) begin
            alu_func = FN_NAND; alu_op1 = b_q;  alu_op2 = b_q;
          end else if (step_q == 5'd1) begin
            alu_func = FN_ADD;  alu_op1 = t0_q; alu_op2 = ONE;
          end else begin
            alu_func = FN_ADD;  alu_op1 = a_q;  alu_op2 = t0_q;
          end
        end
        OP_AND: begin
          if (step_q == 5'd0) begin
            alu_func = FN_NAND; alu_op1 = a_q;  alu_op2 = b_q;
          end else begin
            alu_func = FN_NAND; alu_op1 = t0_q; alu_op2 = t0_q;
          end
        end
        OP_OR: begin
          if (step_q == 5'd0) begin
            alu_func = FN_NAND; alu_op1 = a_q;  alu_op2 = a_q;
          end else if (step_q == 5'd1) begin
            alu_func = FN_NAND; alu_op1 = b_q;  alu_op2 = b_q;
          end else begin
            alu_func = FN_NAND; alu_op1 = t0_q; alu_op2 = t1_q;
          end
        end
        OP_XOR: begin
          alu_func = FN_NAND;
          if (step_q == 5'd0) begin
            alu_op1 = a_q;  alu_op2 = b_q;
          end else if (step_q == 5'd1) begin
            alu_op1 = a_q;  alu_op2 = t0_q;
          end else if (step_q == 5'd2) begin
            alu_op1 = b_q;  alu_op2 = t0_q;
          end else begin
            alu_op1 = t1_q; alu_op2 = a_q;
          end
        end
        OP_SHL: begin
          if (b_q[3:0] == 4'd0) begin
            alu_func = FN_PASS; alu_op1 = a_q; alu_op2 = ZERO;
          end else begin
            alu_func = FN_ADD;  alu_op1 = a_q; alu_op2 = a_q;
          end
        end
        OP_CMPEQ: begin
          alu_func = FN_EQ; alu_op1 = a_q; alu_op2 = b_q;
        end
`ifdef ALU_MACRO_SEQ_MUL_EN
        OP_MUL: begin
          if (step_q[0] == 1'b0) begin
            if (b_q[0]) begin
              alu_func = FN_ADD;  alu_op1 = acc_q; alu_op2 = a_q;
            end else begin
              alu_func = FN_PASS; alu_op1 = acc_q; alu_op2 = ZERO;
            end
          end else begin
            alu_func = FN_ADD; alu_op1 = a_q; alu_op2 = a_q;
          end
        end
`endif
        default: begin
          alu_func = FN_PASS; alu_op1 = ZERO; alu_op2 = ZERO;
        end
      endcase
    end else begin
      alu_func = FN_PASS;
      alu_op1  = ZERO;
      alu_op2  = ZERO;
    end
  end

  // Datapath next-state: latch request, capture each step's ALU result
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    t0_d   = t0_q;
    t1_d   = t1_q;
    op_d   = op_q;
    step_d = step_q;
    res_d  = resp_result_q;
    err_d  = resp_err_q;
`ifdef ALU_MACRO_SEQ_MUL_EN
    acc_d  = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d    = req_a;
          b_d    = req_b;
          op_d   = req_op;
          step_d = 5'd0;
          t0_d   = ZERO;
          t1_d   = ZERO;
`ifdef ALU_MACRO_SEQ_MUL_EN
          acc_d  = ZERO;
`endif
          if (op_illegal_s) begin
            res_d = ZERO;
            err_d = 1'b1;
          end else begin
            res_d = resp_result_q;
            err_d = resp_err_q;
          end
        end else begin
          step_d = step_q;
        end
      end
      ST_EXEC: begin
        step_d = step_q + 5'd1;
        case (op_q)
          OP_SUB: if (step_q != 5'd2) t0_d = alu_result; else t0_d = t0_q;
          OP_AND: if (step_q == 5'd0) t0_d = alu_result; else t0_d = t0_q;
          OP_OR: begin
            if (step_q == 5'd0)      t0_d = alu_result;
            else if (step_q == 5'd1) t1_d = alu_result;
            else                     t0_d = t0_q;
          end
          OP_XOR: begin
            if (step_q == 5'd0)      t0_d = alu_result;
            else if (step_q == 5'd1) t1_d = alu_result;
            else if (step_q == 5'd2) a_d  = alu_result;
            else                     a_d  = a_q;
          end
          OP_SHL: a_d = alu_result;
`ifdef ALU_MACRO_SEQ_MUL_EN
          OP_MUL: begin
            if (step_q[0] == 1'b0) begin
              if (b_q[0]) acc_d = alu_result;
              else        acc_d = acc_q;
            end else begin
              a_d = alu_result;
              b_d = {1'b0, b_q[WIDTH-1:1]};
            end
          end
`endif
          default: a_d = a_q;
        endcase
        if (last_step_s) begin
          err_d = 1'b0;
          case (op_q)
            OP_CMPEQ: res_d = {{(WIDTH-1){1'b0}}, alu_eq};
`ifdef ALU_MACRO_SEQ_MUL_EN
            OP_MUL:   res_d = acc_q;
`endif
            default:  res_d = alu_result;
          endcase
        end else begin
          res_d = resp_result_q;
        end
      end
      ST_DONE: step_d = step_q;
      default: step_d = 5'd0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 3'd0;
      a_q    <= ZERO;
      b_q    <= ZERO;
      t0_q   <= ZERO;
      t1_q   <= ZERO;
      step_q <= 5'd0;
`ifdef ALU_MACRO_SEQ_MUL_EN
      acc_q  <= ZERO;
`endif
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      t0_q   <= t0_d;
      t1_q   <= t1_d;
      step_q <= step_d;
`ifdef ALU_MACRO_SEQ_MUL_EN
      acc_q  <= acc_d;
`endif
    end
  end

  // Response and status output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result_q <= ZERO;
      resp_err_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
    end else begin
      resp_result_q <= res_d;
      resp_err_q    <= err_d;
      resp_valid_q  <= resp_valid_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
    end
  end

endmodule

// File: doc/alu_macro_seq.md
Name: alu_macro_seq

Overview:
Multi-cycle sequencer that builds compound 16-bit operations (SUB, AND, OR, XOR, SHL, CMPEQ, optional MUL) from the four-function core ALU (ADD, NAND, PASS1, EQ).
Drives the ALU's func/operand inputs one micro-step per clock and captures its result/eq.
Accepts one request at a time over a valid/ready handshake and returns a registered response over a second valid/ready handshake.
Sits between the execute stage and the core ALU instance.

Parameters:
WIDTH, 16, datapath width; fixed at 16 to match the core ALU.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept; high only in IDLE
req_op  input  3  0 SUB, 1 AND, 2 OR, 3 XOR, 4 SHL, 5 MUL, 6 CMPEQ, 7 reserved
req_a  input  16  operand A
req_b  input  16  operand B; SHL amount = req_b[3:0]
resp_valid  output  1  response held until taken
resp_ready  input  1  consumer accepts response
resp_result  output  16  operation result
resp_err  output  1  illegal or disabled opcode
busy  output  1  high in EXEC or DONE
alu_func  output  2  to ALU: 00 ADD, 01 NAND, 10 PASS1, 11 EQ
alu_op1  output  16  to ALU operand1
alu_op2  output  16  to ALU operand2
alu_result  input  16  from ALU, combinational
alu_eq  input  1  from ALU, valid only when alu_func=11

Behaviour:
- Reset (async, rst_n=0): state=IDLE; resp_valid=0, resp_result=0, resp_err=0, busy=0, req_ready=1; internal a, b, t0, t1, step, acc cleared; alu_func=10, alu_op1=alu_op2=0.
- IDLE/DONE: ALU outputs held at PASS1 with zero operands, so no X is ever driven.
- FSM states: IDLE, EXEC, DONE.
- IDLE -> EXEC on req_valid & req_ready; a/b/op latched, step=0.
- IDLE -> DONE directly for op 7, or op 5 without the macro: resp_err=1, result=0, latency 1.
- EXEC: one micro-step per cycle; ALU outputs are combinational from (op, step, regs); result captured at the clock edge.
- EXEC -> DONE after the last step; resp_result is registered and resp_valid=1 from the next cycle.
- DONE -> IDLE on resp_ready. req_ready=0 in DONE, so the earliest next accept is the cycle after the handoff.
- Latency (accept edge to resp_valid) = N micro-steps.
- Micro-steps:
  - SUB (N=3): t0=NAND(b,b); t0=ADD(t0,1); res=ADD(a,t0).
  - AND (N=2): t0=NAND(a,b); res=NAND(t0,t0).
  - OR (N=3): t0=NAND(a,a); t1=NAND(b,b); res=NAND(t0,t1).
  - XOR (N=4): t0=NAND(a,b); t1=NAND(a,t0); a=NAND(b,t0); res=NAND(t1,a).
  - SHL (N=max(n,1), n=b[3:0]): n=0 -> res=PASS1(a); otherwise n steps of a=ADD(a,a), res=final a.
  - CMPEQ (N=1): EQ(a,b); res={15'b0, alu_eq}.
- All arithmetic is modulo 2^16; carries are discarded.
- req_op/req_a/req_b are ignored while not in IDLE.
- resp_result/resp_err are stable while resp_valid=1 and resp_ready=0.
- rst_n low mid-operation aborts immediately to the reset state; no response is issued.

Optional Feature:
- Macro ALU_MACRO_SEQ_MUL_EN.
- Defined: op 5 = MUL, low 16 bits of a*b, N=32 fixed.
  - Even step: if b[0], acc=ADD(acc,a); otherwise PASS1(acc) and acc is unchanged.
  - Odd step: a=ADD(a,a), then b is shifted right one bit in a register (not via the ALU).
  - res=acc.
- Undefined: no acc register or MUL logic; op 5 behaves as op 7 (resp_err=1, result 0, latency 1).

Test Plan:
- Reset mid-SHL (b=15) at step 7 -> all outputs at reset values immediately; next request completes normally.
- SUB a=5, b=3 -> resp_result=0x0002, err=0, resp_valid 3 cycles after accept; SUB 0x0000-0x0001 -> 0xFFFF.
- XOR a=0xF0F0, b=0xFF00 -> 0x0FF0 after 4 cycles; OR same operands -> 0xFFF0; AND -> 0xF000.
- SHL a=0x0001, b=15 -> 0x8000 after 15 cycles; SHL b=0 -> 0x0001 after 1 cycle; alu_func=00 on every SHL step.
- CMPEQ 0x1234/0x1234 -> 0x0001, 0x1234/0x1235 -> 0x0000; hold resp_ready=0 for 5 cycles -> result stable, req_ready=0, new req_valid ignored.
- op 7 -> err=1, result 0, latency 1; with MUL_EN, MUL 300*300 -> 0x5F90 after 32 cycles; without it, op 5 -> err=1.
